// File: rtl/tpu_controller_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tpu_ctrl_pkg : opcodes, instruction fields and FSM state encoding  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package tpu_ctrl_pkg;

   localparam int INSTR_W     = 32;
   localparam int OP_MSB      = 31;
   localparam int OP_LSB      = 28;
   localparam int BASE_MSB    = 27;
   localparam int BASE_LSB    = 20;
   localparam int CNT_MSB     = 19;
   localparam int CNT_LSB     = 12;
   localparam int ARRAY_N_DEF = 16;
   localparam int MMU_LAT_DEF = 32;
   localparam int IDX_W       = 9;
   localparam int MM_W        = 16;

   typedef enum logic [3:0] {
      OP_NOP          = 4'd0,
      OP_WRITE_DATA   = 4'd1,
      OP_WRITE_WEIGHT = 4'd2,
      OP_LOAD_WEIGHT  = 4'd3,
      OP_MAT_MUL      = 4'd4,
      OP_WRITE_RESULT = 4'd5
   } opcode_e;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_WRBUF = 3'd1,
      ST_RDW   = 3'd2,
      ST_MM    = 3'd3,
      ST_RES   = 3'd4
   } state_e;

   function automatic logic op_is_legal(input logic [3:0] op);
      return op <= 4'd5;
   endfunction

endpackage
`default_nettype wire

// File: rtl/tpu_controller_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tpu_controller_if : host instruction and host data handshakes      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface tpu_controller_if
   import tpu_ctrl_pkg::*;
#(
   parameter int DATA_W = 128
);
   logic [INSTR_W-1:0] instruction;
   logic               instr_valid;
   logic               instr_ready;
   logic [DATA_W-1:0]  host_din;
   logic               host_valid;
   logic               host_ready;

   modport master (
      output instruction, instr_valid, host_din, host_valid,
      input  instr_ready, host_ready
   );

   modport slave (
      input  instruction, instr_valid, host_din, host_valid,
      output instr_ready, host_ready
   );
endinterface
`default_nettype wire

// File: rtl/tpu_instr_decode.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tpu_instr_decode : splits instruction fields, flags legal opcodes  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tpu_instr_decode
   import tpu_ctrl_pkg::*;
(
   input  logic [INSTR_W-1:0] i_instr,
   output opcode_e            o_op,
   output logic [7:0]         o_base,
   output logic [7:0]         o_count,
   output logic               o_legal
);
   logic w_unused_rsvd;

   assign o_op          = opcode_e'(i_instr[OP_MSB:OP_LSB]);
   assign o_base        = i_instr[BASE_MSB:BASE_LSB];
   assign o_count       = i_instr[CNT_MSB:CNT_LSB];
   assign o_legal       = op_is_legal(i_instr[OP_MSB:OP_LSB]);
   assign w_unused_rsvd = ^i_instr[11:0];
endmodule
`default_nettype wire

// File: rtl/tpu_controller.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tpu_controller : systolic-array instruction sequencer              |
// | Optional MAC-cycle counter: define TPU_CTRL_PERF_EN. Rev 1.0       |
// +--------------------------------------------------------------------+
module tpu_controller
   import tpu_ctrl_pkg::*;
#(
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 128,
   parameter int ARRAY_N = ARRAY_N_DEF,
   parameter int MMU_LAT = MMU_LAT_DEF
)(
   input  logic              clk,
   input  logic              reset_n,
   tpu_controller_if.slave   bus,
   output logic              write_data,
   output logic              write_weight,
   output logic              read_en,
   output logic [ADDR_W-1:0] addra,
   output logic [ADDR_W-1:0] addrb,
   output logic [DATA_W-1:0] dout,
   output logic              load_weight,
   output logic              load_data,
   output logic              mat_mul,
   output logic              write_result,
   output logic              busy,
   output logic              err,
   output logic [31:0]       perf_mac_cycles
);
   state_e            r_state, w_state_nx;
   logic [7:0]        r_base, w_base_nx;
   logic [IDX_W-1:0]  r_idx, w_idx_nx, r_limit, w_limit_nx;
   logic [MM_W-1:0]   r_mm_left, w_mm_left_nx;
   logic              r_is_wt, w_is_wt_nx, r_err, w_err_nx;
   logic              r_wd, w_wd_nx, r_ww, w_ww_nx, r_rd, w_rd_nx, r_wr, w_wr_nx;
   logic              r_ldw, w_ldw_nx, r_ldd, w_ldd_nx, r_mm, w_mm_nx;
   logic [ADDR_W-1:0] r_addra, w_addra_nx, r_addrb, w_addrb_nx, w_addr_off;
   logic [DATA_W-1:0] r_dout, w_dout_nx;
   opcode_e           w_dec_op;
   logic [7:0]        w_dec_base, w_dec_count;
   logic              w_dec_legal, w_accept, w_host_fire;

   tpu_instr_decode u_decode (
      .i_instr (bus.instruction),
      .o_op    (w_dec_op),
      .o_base  (w_dec_base),
      .o_count (w_dec_count),
      .o_legal (w_dec_legal)
   );

   assign bus.instr_ready = (r_state == ST_IDLE);
   assign bus.host_ready  = (r_state == ST_WRBUF) && (r_idx != r_limit);
   assign w_accept        = bus.instr_valid && (r_state == ST_IDLE);
   assign w_host_fire     = bus.host_valid && bus.host_ready;
   assign w_addr_off      = ADDR_W'({1'b0, r_base} + r_idx);

   // The first read/drain strobe is issued on the accepting edge, so r_idx
   // counts strobes already issued rather than the current position.
   always_comb begin
      w_state_nx = r_state;    w_base_nx   = r_base;    w_idx_nx  = r_idx;
      w_limit_nx = r_limit;    w_is_wt_nx  = r_is_wt;   w_err_nx  = r_err;
      w_wd_nx    = 1'b0;       w_ww_nx     = 1'b0;      w_rd_nx   = 1'b0;
      w_wr_nx    = 1'b0;       w_addra_nx  = r_addra;   w_addrb_nx = r_addrb;
      w_dout_nx  = r_dout;
      w_ldw_nx     = r_rd && (r_state == ST_RDW);
      w_ldd_nx     = r_rd && (r_state == ST_MM);
      w_mm_nx      = (r_mm_left != '0) && (r_mm || w_ldd_nx);
      w_mm_left_nx = w_mm_nx ? r_mm_left - MM_W'(1) : r_mm_left;
      case (r_state)
         ST_IDLE: if (w_accept) begin
            w_base_nx  = w_dec_base;
            w_idx_nx   = '0;
            w_limit_nx = {1'b0, w_dec_count};
            if (!w_dec_legal) begin
               w_err_nx = 1'b1;
            end else begin
               case (w_dec_op)
                  OP_WRITE_DATA, OP_WRITE_WEIGHT: begin
                     w_state_nx = ST_WRBUF;
                     w_is_wt_nx = (w_dec_op == OP_WRITE_WEIGHT);
                  end
                  OP_LOAD_WEIGHT: begin
                     w_state_nx = ST_RDW;   w_limit_nx = IDX_W'(ARRAY_N);
                     w_idx_nx   = IDX_W'(1); w_rd_nx   = 1'b1;
                     w_addrb_nx = ADDR_W'(w_dec_base);
                  end
                  OP_MAT_MUL: begin
                     w_state_nx = ST_MM;
                     if (w_dec_count != 8'd0) begin
                        w_idx_nx     = IDX_W'(1);
                        w_rd_nx      = 1'b1;
                        w_addrb_nx   = ADDR_W'(w_dec_base);
                        w_mm_left_nx = MM_W'(w_dec_count) + MM_W'(MMU_LAT);
                     end
                  end
                  OP_WRITE_RESULT: begin
                     w_state_nx = ST_RES;   w_limit_nx = IDX_W'(ARRAY_N);
                     w_idx_nx   = IDX_W'(1); w_wr_nx   = 1'b1;
                  end
                  OP_NOP:  ;
                  default: ;
               endcase
            end
         end
         ST_WRBUF: begin
            if (r_idx == r_limit) begin
               w_state_nx = ST_IDLE;
            end else if (w_host_fire) begin
               w_wd_nx    = !r_is_wt;
               w_ww_nx    = r_is_wt;
               w_addra_nx = w_addr_off;
               w_dout_nx  = bus.host_din;
               w_idx_nx   = r_idx + IDX_W'(1);
               if (r_idx + IDX_W'(1) == r_limit) w_state_nx = ST_IDLE;
            end
         end
         ST_RDW, ST_MM: begin
            if (r_idx < r_limit) begin
               w_rd_nx    = 1'b1;
               w_addrb_nx = w_addr_off;
               w_idx_nx   = r_idx + IDX_W'(1);
            end else if (!r_rd && (r_mm_left == '0)) begin
               w_state_nx = ST_IDLE;
            end
         end
         ST_RES: begin
            if (r_idx < r_limit) begin
               w_wr_nx  = 1'b1;
               w_idx_nx = r_idx + IDX_W'(1);
            end else begin
               w_state_nx = ST_IDLE;
            end
         end
         default: w_state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE; r_base <= '0; r_idx <= '0; r_limit <= '0;
         r_mm_left <= '0; r_is_wt <= 1'b0; r_err <= 1'b0;
         r_wd <= 1'b0; r_ww <= 1'b0; r_rd <= 1'b0; r_wr <= 1'b0;
         r_ldw <= 1'b0; r_ldd <= 1'b0; r_mm <= 1'b0;
         r_addra <= '0; r_addrb <= '0; r_dout <= '0;
      end else begin
         r_state <= w_state_nx; r_base <= w_base_nx; r_idx <= w_idx_nx;
         r_limit <= w_limit_nx; r_mm_left <= w_mm_left_nx;
         r_is_wt <= w_is_wt_nx; r_err <= w_err_nx;
         r_wd <= w_wd_nx; r_ww <= w_ww_nx; r_rd <= w_rd_nx; r_wr <= w_wr_nx;
         r_ldw <= w_ldw_nx; r_ldd <= w_ldd_nx; r_mm <= w_mm_nx;
         r_addra <= w_addra_nx; r_addrb <= w_addrb_nx; r_dout <= w_dout_nx;
      end
   end

`ifdef TPU_CTRL_PERF_EN
   logic [31:0] r_perf;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                      r_perf <= '0;
      else if (r_mm && (r_perf != '1))   r_perf <= r_perf + 32'd1;
   end
   assign perf_mac_cycles = r_perf;
`else
   assign perf_mac_cycles = '0;
`endif

   assign write_data   = r_wd;
   assign write_weight = r_ww;
   assign read_en      = r_rd;
   assign addra        = r_addra;
   assign addrb        = r_addrb;
   assign dout         = r_dout;
   assign load_weight  = r_ldw;
   assign load_data    = r_ldd;
   assign mat_mul      = r_mm;
   assign write_result = r_wr;
   assign busy         = (r_state != ST_IDLE);
   assign err          = r_err;
endmodule
`default_nettype wire

// File: tb/tb_tpu_controller.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_tpu_controller : directed vectors with a strobe scoreboard      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_tpu_controller;
   import tpu_ctrl_pkg::*;

   localparam logic [6:0] S_WD = 7'b1000000, S_WW = 7'b0100000, S_RD = 7'b0010000;
   localparam logic [6:0] S_LW = 7'b0001000, S_LD = 7'b0000100, S_MM = 7'b0000010;
   localparam logic [6:0] S_WR = 7'b0000001;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   tpu_controller_if #(.DATA_W(128)) bus();
   logic         write_data, write_weight, read_en, load_weight, load_data;
   logic         mat_mul, write_result, busy, err;
   logic [7:0]   addra, addrb;
   logic [127:0] dout;
   logic [31:0]  perf_mac_cycles;

   tpu_controller #(.ADDR_W(8), .DATA_W(128), .ARRAY_N(16), .MMU_LAT(32)) dut (
      .clk(clk), .reset_n(reset_n), .bus(bus),
      .write_data(write_data), .write_weight(write_weight), .read_en(read_en),
      .addra(addra), .addrb(addrb), .dout(dout),
      .load_weight(load_weight), .load_data(load_data), .mat_mul(mat_mul),
      .write_result(write_result), .busy(busy), .err(err),
      .perf_mac_cycles(perf_mac_cycles)
   );

   typedef struct packed {
      logic [6:0]   s;
      logic [7:0]   aa;
      logic [7:0]   ab;
      logic [127:0] d;
   } beat_t;

   beat_t exp_q[$];
   int    n_vec  = 0;
   int    n_fail = 0;
   bit    mon_en = 1'b0;

   function automatic beat_t mk(logic [6:0] s, logic [7:0] aa, logic [7:0] ab, logic [127:0] d);
      beat_t b;
      b.s = s; b.aa = aa; b.ab = ab; b.d = d;
      return b;
   endfunction

   // Every cycle showing any strobe consumes one expected beat.
   always @(negedge clk) begin
      beat_t      e;
      logic [6:0] act;
      bit         ok;
      act = {write_data, write_weight, read_en, load_weight, load_data, mat_mul, write_result};
      if (mon_en && act != 7'd0) begin
         n_vec++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_strobe: got strobes %b, required none at t=%0t", act, $time);
         end else begin
            e  = exp_q.pop_front();
            ok = (act === e.s);
            if ((e.s & (S_WD | S_WW)) != 7'd0) ok = ok && (addra === e.aa) && (dout === e.d);
            if ((e.s & S_RD) != 7'd0)          ok = ok && (addrb === e.ab);
            if (!ok) begin
               n_fail++;
               $display("FAIL beat: got s=%b aa=%h ab=%h d=%h, required s=%b aa=%h ab=%h d=%h",
                        act, addra, addrb, dout, e.s, e.aa, e.ab, e.d);
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", nm, act, req);
      end
   endtask

   task automatic send(input logic [3:0] op, input logic [7:0] base, input logic [7:0] cnt,
                       output int waited);
      logic rdy;
      waited = 0;
      bus.instruction = {op, base, cnt, 12'hA5C};
      bus.instr_valid = 1'b1;
      while (1) begin
         @(negedge clk); rdy = bus.instr_ready;
         @(posedge clk); #1;
         if (rdy) break;
         waited++;
         if (waited > 300) begin
            chk("instr_accept_timeout", 32'(waited), 32'd0);
            break;
         end
      end
      bus.instr_valid = 1'b0;
   endtask

   task automatic host_beat(input logic [127:0] d);
      logic rdy;
      int   n;
      n = 0;
      bus.host_din   = d;
      bus.host_valid = 1'b1;
      while (1) begin
         @(negedge clk); rdy = bus.host_ready;
         @(posedge clk); #1;
         if (rdy) break;
         n++;
         if (n > 300) begin
            chk("host_accept_timeout", 32'(n), 32'd0);
            break;
         end
      end
      bus.host_valid = 1'b0;
   endtask

   task automatic busy_len(output int n);
      n = 0;
      while (busy && n < 500) begin
         n++;
         @(posedge clk); #1;
      end
   endtask

   initial begin
      int w, n;
      bus.instruction = '0; bus.instr_valid = 1'b0;
      bus.host_din    = '0; bus.host_valid  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_instr_ready", 32'(bus.instr_ready), 32'd1);
      chk("rst_busy",        32'(busy), 32'd0);
      chk("rst_err",         32'(err), 32'd0);
      chk("rst_strobes",     32'({write_data, write_weight, read_en, load_weight,
                                  load_data, mat_mul, write_result}), 32'd0);
      chk("rst_perf",        perf_mac_cycles, 32'd0);
      reset_n = 1'b1;
      @(posedge clk); #1;

      // Reset in the middle of a MAT_MUL
      send(4'h4, 8'h00, 8'd8, w);
      repeat (3) @(posedge clk);
      #1;
      chk("mid_mm_read_en", 32'(read_en), 32'd1);
      reset_n = 1'b0;
      #1;
      chk("mid_rst_strobes", 32'({write_data, write_weight, read_en, load_weight,
                                  load_data, mat_mul, write_result}), 32'd0);
      chk("mid_rst_instr_ready", 32'(bus.instr_ready), 32'd1);
      chk("mid_rst_err",  32'(err), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      mon_en  = 1'b1;
      repeat (40) @(posedge clk);
      #1;
      chk("post_rst_busy", 32'(busy), 32'd0);

      // WRITE_DATA with address wrap and a two-cycle host gap
      exp_q.push_back(mk(S_WD, 8'hFE, 8'h00, 128'hAAAA_0001));
      exp_q.push_back(mk(S_WD, 8'hFF, 8'h00, 128'hBBBB_0002));
      exp_q.push_back(mk(S_WD, 8'h00, 8'h00, 128'hCCCC_0003));
      send(4'h1, 8'hFE, 8'd3, w);
      chk("wrbuf_host_ready", 32'(bus.host_ready), 32'd1);
      host_beat(128'hAAAA_0001);
      repeat (2) @(posedge clk);
      #1;
      host_beat(128'hBBBB_0002);
      host_beat(128'hCCCC_0003);
      @(posedge clk); #1;
      chk("wrbuf_done_host_ready", 32'(bus.host_ready), 32'd0);
      chk("wrbuf_done_busy", 32'(busy), 32'd0);

      // WRITE_WEIGHT, back-to-back beats
      exp_q.push_back(mk(S_WW, 8'h30, 8'h00, 128'h1234_5678_9ABC_DEF0));
      exp_q.push_back(mk(S_WW, 8'h31, 8'h00, 128'hFFFF_0000_FFFF_0000));
      send(4'h2, 8'h30, 8'd2, w);
      host_beat(128'h1234_5678_9ABC_DEF0);
      host_beat(128'hFFFF_0000_FFFF_0000);

      // host_valid while idle is ignored
      @(posedge clk); #1;
      bus.host_din   = 128'hDEAD;
      bus.host_valid = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("idle_host_ready", 32'(bus.host_ready), 32'd0);
      bus.host_valid = 1'b0;

      // LOAD_WEIGHT base 0x10, count field ignored
      for (int i = 0; i <= 16; i++)
         exp_q.push_back(mk(((i < 16) ? S_RD : 7'd0) | ((i > 0) ? S_LW : 7'd0),
                            8'h00, 8'(8'h10 + i), 128'd0));
      send(4'h3, 8'h10, 8'hFF, w);
      busy_len(n);
      chk("lw_busy_cycles", 32'(n), 32'd17);

      // MAT_MUL base 0 count 4
      for (int i = 0; i <= 36; i++)
         exp_q.push_back(mk(((i < 4) ? S_RD : 7'd0) | ((i >= 1 && i <= 4) ? S_LD : 7'd0) |
                            ((i >= 1) ? S_MM : 7'd0), 8'h00, 8'(i), 128'd0));
      send(4'h4, 8'h00, 8'd4, w);
      busy_len(n);
      chk("mm_idle_timeout", 32'(busy), 32'd0);
`ifdef TPU_CTRL_PERF_EN
      chk("perf_mac_cycles", perf_mac_cycles, 32'd36);
`else
      chk("perf_mac_cycles", perf_mac_cycles, 32'd0);
`endif

      // Illegal opcode, NOP, then WRITE_RESULT with the next instruction held
      send(4'hA, 8'h12, 8'd5, w);
      chk("illegal_err",  32'(err), 32'd1);
      chk("illegal_busy", 32'(busy), 32'd0);
      send(4'h0, 8'h00, 8'd7, w);
      chk("nop_busy", 32'(busy), 32'd0);
      chk("nop_err",  32'(err), 32'd1);
      for (int i = 0; i < 16; i++)
         exp_q.push_back(mk(S_WR, 8'h00, 8'h00, 128'd0));
      send(4'h5, 8'h00, 8'd0, w);
      send(4'h4, 8'h40, 8'd0, w);
      chk("hold_wait_cycles", 32'(w), 32'd16);
      busy_len(n);
      chk("mm_count0_busy", 32'(n), 32'd1);
      chk("final_err", 32'(err), 32'd1);

      repeat (5) @(posedge clk);
      #1;
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      mon_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required finish before t=200000");
      $fatal(1);
   end
endmodule
`default_nettype wire
